alu_exec_unit: RTL
==================

# alu_exec_unit

Execute-stage ALU that consumes the 4-bit ALUOp from ALU control and the two register/immediate operands, and produces a registered result, zero/slt-style flags, and the HI/LO product registers read by mfhi/mflo. Single-cycle ops complete one cycle after start. `mul` runs on a sequential signed shift-add multiplier with a start/busy/done handshake, so the control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 16: datapath width. Must be a power of two, at least 8.
- `SHW`, $clog2(WIDTH): shift-amount width.

- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request an operation. Sampled only when `busy`=0.
- `alu_op`  in  4  ALUOp code, captured with `start`.
- `a`  in  WIDTH  operand A / shift source, captured with `start`.
- `b`  in  WIDTH  operand B. Shift amount is `b[SHW-1:0]`. Captured with `start`.
- `result`  out  WIDTH  registered result. Holds its value until the next `done`.
- `zero`  out  1  `result`==0, registered with `result`.
- `done`  out  1  one-cycle pulse: `result`/`zero`/`err` are valid.
- `busy`  out  1  multiply in progress. `start` is ignored while high.
- `err`  out  1  last captured `alu_op` was unsupported.
- `hi`  out  WIDTH  upper product half, for mfhi.
- `lo`  out  WIDTH  lower product half, for mflo.

## Operation
- ALUOp decode:
  - 0010 add
  - 0000 and
  - 0110 sub (also used for beq/bne via `zero`)
  - 0001 or
  - 1001 xor
  - 1010 nor
  - 0111 slt: signed compare, result 1 or 0
  - 1000 mul: signed
  - 1100 sll
  - 0011 srl
  - 1101 sra
- Any other code, including X or Z: `result`=0, `zero`=1, `err`=1, `done` pulses with single-cycle latency. `hi`/`lo` are unchanged.
- Add and sub wrap modulo 2^WIDTH. No overflow output.
- Shifts use only `b[SHW-1:0]`. Upper bits of `b` are ignored.
- mul:
  - Capture the sign of each operand and their absolute values. `abs(-2^(WIDTH-1))` is 2^(WIDTH-1), held as unsigned.
  - Run WIDTH add-shift iterations into a 2·WIDTH-bit accumulator.
  - Negate the accumulator if the operand signs differ.
  - On `done`: {`hi`,`lo`} = product, `result` = product low half, `zero` = (low half == 0).
- `hi`/`lo` change only on mul completion or reset.
- FSM states:
  - IDLE: `start` with non-mul op → `result` registered, `done`=1 next cycle, stay in IDLE. `start` with mul → MUL, counter=0, `busy`=1.
  - MUL: one iteration per cycle; counter increments. At counter==WIDTH-1 → FIN.
  - FIN: apply sign fix, write `hi`/`lo`/`result`, `done`=1, `busy`=0, → IDLE.
- `start` during MUL or FIN is dropped, not queued. The control unit must hold the instruction.
- Reset (any state, including mid-multiply) puts every output to 0 (`zero`=0) and the FSM to IDLE. The in-flight multiply is discarded.

## Timing
- Start sampled at edge E0.
- Non-mul: `done` is high for the cycle following E0. Latency 1. Back-to-back `start` every cycle is legal.
- mul:
  - `busy` is high from E0 until the cycle following the FIN edge.
  - `done` is high in cycle WIDTH+1 after the start cycle (17 for WIDTH=16), with `busy` already low.
  - A new `start` may be presented in the `done` cycle.
- `done` is never high for two consecutive cycles from a single `start`.
- `result`, `zero`, `err` are stable between `done` pulses.

## Structure
- Shared package `alu_pkg` holds:
  - ALUOp localparams (ALU_ADD, ALU_AND, ALU_SUB, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_MUL, ALU_SLL, ALU_SRL, ALU_SRA).
  - The FSM state enum (IDLE, MUL, FIN).
- ALU control uses the same package for its encodings.
- Sub-module `seq_mult_signed`:
  - Handles sign capture, the iteration counter and the accumulator.
  - Ports: `clk`, `rst`, `start`, `a`, `b`, `busy`, `done`, `product[2·WIDTH-1:0]`.
- `alu_exec_unit` holds the combinational op mux, the output registers and the `hi`/`lo` registers.

## Test plan
- Add, then sub: 0x7FFF+0x0001 → `result`=0x8000, `zero`=0, `done` in the next cycle. Then 0x0005−0x0005 → 0x0000, `zero`=1.
- slt, then nor: a=0xFFFF, b=0x0001 → `result`=1. Then nor 0x0F0F,0x00FF → 0xF000.
- Shifts:
  - sra 0x8000 by b=3 → 0xF000.
  - srl 0x8000 by 3 → 0x1000.
  - sll 0x0001 by b=0x0011 (shamt 1) → 0x0002.
- mul signed: 0xFFFD × 0x0007 → `busy` high 16 cycles, `done` at cycle 17, `hi`=0xFFFF, `lo`=`result`=0xFFEB. Also 0x8000 × 0x8000 → `hi`=0x4000, `lo`=0x0000, `zero`=1.
- Handshake: `start` with add asserted at cycle 5 of a mul → ignored, single `done` from the mul, `hi`/`lo` correct. Illegal op 0x4 (4'b0100) → `result`=0, `err`=1, `hi`/`lo` unchanged.
- Reset mid-mul: assert `rst` at cycle 8 → next cycle `busy`/`done`/`hi`/`lo`/`result`=0. A following add 2+3 → `result`=5 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALUOp encodings and multiplier sequencing states for the execute stage.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SRL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1010;
    localparam logic [3:0] ALU_SLL = 4'b1100;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } mult_state_t;

endpackage

// File: rtl/seq_mult_signed.sv
// Sequential signed shift-add multiplier: magnitude product over WIDTH iterations,
// sign restored on the last one. product is valid while done is high.
module seq_mult_signed
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_MUL_CNT = CW'(WIDTH - 2);

    mult_state_t          state_q;
    logic [CW-1:0]        cnt_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;

    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [2*WIDTH-1:0]   acc_d;

    // The most negative operand maps to 2^(WIDTH-1), which fits as unsigned.
    assign a_abs = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_abs = b[WIDTH-1] ? (~b + 1'b1) : b;

    assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product = neg_q ? ('0 - acc_d) : acc_d;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN);

    // MUL runs WIDTH-1 iterations; FIN performs the last one combinationally
    // so the parent can register the signed product on the FIN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= MUL;
                        cnt_q    <= '0;
                        neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, a_abs};
                        mplier_q <= b_abs;
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_MUL_CNT) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops through a combinational mux, signed mul through
// the sequential multiplier, with registered result/flags and HI/LO product registers.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0]     result_q;
    logic                 zero_q;
    logic                 done_q;
    logic                 err_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic [WIDTH-1:0]     alu_res_d;
    logic                 op_err_d;
    logic                 is_mul_d;
    logic [SHW-1:0]       shamt;
    logic                 accept;
    logic                 mult_busy;
    logic                 mult_done;
    logic [2*WIDTH-1:0]   mult_product;

    assign shamt  = b[SHW-1:0];
    assign accept = start & ~mult_busy;

    // Unknown codes (including X/Z in simulation) fall to default: result 0, err set.
    always_comb begin
        alu_res_d = '0;
        op_err_d  = 1'b0;
        is_mul_d  = 1'b0;
        case (alu_op)
            ALU_ADD: alu_res_d = a + b;
            ALU_SUB: alu_res_d = a - b;
            ALU_AND: alu_res_d = a & b;
            ALU_OR:  alu_res_d = a | b;
            ALU_XOR: alu_res_d = a ^ b;
            ALU_NOR: alu_res_d = ~(a | b);
            ALU_SLT: alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_MUL: is_mul_d  = 1'b1;
            ALU_SLL: alu_res_d = a << shamt;
            ALU_SRL: alu_res_d = a >> shamt;
            ALU_SRA: alu_res_d = $signed(a) >>> shamt;
            default: op_err_d  = 1'b1;
        endcase
    end

    seq_mult_signed #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (accept & is_mul_d),
        .a       (a),
        .b       (b),
        .busy    (mult_busy),
        .done    (mult_done),
        .product (mult_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (mult_done) begin
                hi_q     <= mult_product[2*WIDTH-1:WIDTH];
                lo_q     <= mult_product[WIDTH-1:0];
                result_q <= mult_product[WIDTH-1:0];
                zero_q   <= (mult_product[WIDTH-1:0] == '0);
                err_q    <= 1'b0;
                done_q   <= 1'b1;
            end else if (accept && !is_mul_d) begin
                result_q <= alu_res_d;
                zero_q   <= (alu_res_d == '0);
                err_q    <= op_err_d;
                done_q   <= 1'b1;
            end
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign done   = done_q;
    assign err    = err_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign busy   = mult_busy;

endmodule
